lfsr_keystream_ctrl: RTL

Sequencer for the 80-bit seeded LFSR (parallel load, shift enable, serial out). On a start request it loads a seed, optionally runs warm-up shifts with output discarded, then streams a programmed number of keystream bits to a consumer over a valid/ready handshake. It sits between the cipher/top-level control and the LFSR instance, and is the only driver of the LFSR's load and shift controls.

---
 rtl/lfsr_ctrl_pkg.sv | 28 ++
 rtl/lfsr_ctrl_counter.sv | 45 ++++
 rtl/lfsr_keystream_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/lfsr_ctrl_pkg.sv
// Shared types and constants for the LFSR keystream sequencer.
// Optional warm-up phase is enabled by defining LFSR_KEYSTREAM_WARMUP_EN.
package lfsr_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_WARMUP = 3'd2,
      ST_STREAM = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

   localparam int unsigned DEF_WIDTH         = 80;
   localparam int unsigned DEF_LEN_W         = 16;
   localparam int unsigned DEF_WARMUP_CYCLES = 160;

   // Width needed to hold the value 'cycles'; never narrower than one bit.
   function automatic int unsigned warm_cnt_w(input int unsigned cycles);
      int unsigned w;
      if (cycles == 32'd0) begin
         w = 32'd1;
      end else begin
         w = $clog2(cycles + 32'd1);
      end
      return w;
   endfunction

endpackage

// File: rtl/lfsr_ctrl_counter.sv
// Loadable down-counter with zero and last (count == 1) flags.
// Saturates at zero; a load takes priority over a decrement.
module lfsr_ctrl_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o,
   output logic         last_o
);

   localparam logic [W-1:0] ZERO_C = {W{1'b0}};
   localparam logic [W-1:0] ONE_C  = W'(1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: load, saturating decrement, or hold.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != ZERO_C)) begin
         cnt_d = cnt_q - ONE_C;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= ZERO_C;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == ZERO_C);
   assign last_o = (cnt_q == ONE_C);

endmodule

// File: rtl/lfsr_keystream_ctrl.sv
// Sequencer for an external seeded LFSR: load seed, optional warm-up
// shifts (LFSR_KEYSTREAM_WARMUP_EN), then stream num_bits keystream bits
// over a valid/ready handshake. Sole driver of the LFSR load/shift controls.
module lfsr_keystream_ctrl
   import lfsr_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH         = DEF_WIDTH,
   parameter int unsigned LEN_W         = DEF_LEN_W,
   parameter int unsigned WARMUP_CYCLES = DEF_WARMUP_CYCLES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] seed_in,
   input  logic [LEN_W-1:0] num_bits,
   output logic             lfsr_par_load,
   output logic             lfsr_shift_en,
   output logic [WIDTH-1:0] lfsr_seed,
   input  logic             lfsr_ser_out,
   output logic             key_bit,
   output logic             key_valid,
   input  logic             key_ready,
   output logic             busy,
   output logic             done
);

   state_e           state_q;
   state_e           state_d;
   logic [WIDTH-1:0] seed_q;

   logic start_acc_s;
   logic stream_xfer_s;
   logic bit_zero_s;
   logic bit_last_s;
   logic warm_done_s;

   // A start is only taken in IDLE and loses to a simultaneous abort.
   assign start_acc_s   = (state_q == ST_IDLE) && start && !abort;
   assign stream_xfer_s = (state_q == ST_STREAM) && key_ready && !abort;

   // Bit counter doubles as the captured length: zero means an empty run.
   lfsr_ctrl_counter #(
      .W (LEN_W)
   ) u_bit_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (start_acc_s),
      .load_val_i (num_bits),
      .dec_i      (stream_xfer_s),
      .zero_o     (bit_zero_s),
      .last_o     (bit_last_s)
   );

`ifdef LFSR_KEYSTREAM_WARMUP_EN
   localparam int unsigned     WCW         = warm_cnt_w(WARMUP_CYCLES);
   localparam logic [WCW-1:0]  WARM_LOAD_C = WCW'(WARMUP_CYCLES);
   localparam logic            WARM_EN_C   = (WARMUP_CYCLES > 32'd0);

   logic warm_dec_s;
   logic warm_zero_s;
   logic warm_last_s;

   assign warm_dec_s = (state_q == ST_WARMUP) && !abort;

   lfsr_ctrl_counter #(
      .W (WCW)
   ) u_warm_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (start_acc_s),
      .load_val_i (WARM_LOAD_C),
      .dec_i      (warm_dec_s),
      .zero_o     (warm_zero_s),
      .last_o     (warm_last_s)
   );

   // Zero is a safety exit so the phase can never stall.
   assign warm_done_s = warm_last_s | warm_zero_s;
`else
   localparam logic WARM_EN_C = 1'b0;

   logic unused_warmup_s;
   assign unused_warmup_s = (WARMUP_CYCLES != 32'd0);
   assign warm_done_s     = 1'b1;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Seed capture on an accepted start; drives the LFSR parallel-load data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seed_q <= {WIDTH{1'b0}};
      end else if (start_acc_s) begin
         seed_q <= seed_in;
      end else begin
         seed_q <= seed_q;
      end
   end

   // Next-state logic; abort overrides every transition.
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_d = ST_LOAD;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_LOAD: begin
               if (bit_zero_s) begin
                  state_d = ST_DONE;
               end else if (WARM_EN_C) begin
                  state_d = ST_WARMUP;
               end else begin
                  state_d = ST_STREAM;
               end
            end
            ST_WARMUP: begin
               if (warm_done_s) begin
                  state_d = ST_STREAM;
               end else begin
                  state_d = ST_WARMUP;
               end
            end
            ST_STREAM: begin
               if (stream_xfer_s && bit_last_s) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_STREAM;
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Output decode from the current state; abort drops every control at once.
   always_comb begin
      lfsr_par_load = 1'b0;
      lfsr_shift_en = 1'b0;
      key_valid     = 1'b0;
      key_bit       = 1'b0;
      done          = 1'b0;
      busy          = (state_q != ST_IDLE);
      case (state_q)
         ST_LOAD: begin
            lfsr_par_load = !abort;
         end
         ST_WARMUP: begin
            lfsr_shift_en = !abort;
         end
         ST_STREAM: begin
            key_valid     = !abort;
            key_bit       = lfsr_ser_out;
            lfsr_shift_en = key_ready && !abort;
         end
         ST_DONE: begin
            done = !abort;
         end
         default: begin
            lfsr_par_load = 1'b0;
         end
      endcase
   end

   assign lfsr_seed = seed_q;

endmodule
